record_packer: RTL and testbench
================================

// Module: record_packer
// PURPOSE
//  Upstream feeder of the registered multibuffer queue. Accepts DATA_OUT_WIDTH-bit
//  records one per cycle, packs REC_PER_WORD of them LSB-first into one
//  Q_DATA_WIDTH-bit word and writes it to the queue's write port, honouring
//  waitrequest. Partial words are pushed on flush. The top bits carry the record count.
// PARAMETERS
//  Q_DATA_WIDTH    128  queue write-word width
//  DATA_OUT_WIDTH  42   record width (= queue read width)
//  REC_PER_WORD    Q_DATA_WIDTH/DATA_OUT_WIDTH (=3), derived localparam
//  CNT_WIDTH       2    count field width; REC_PER_WORD*DATA_OUT_WIDTH+CNT_WIDTH <= Q_DATA_WIDTH
//  TIMEOUT_CYCLES  64   idle cycles before auto-flush (PACKER_TIMEOUT_FLUSH_EN only)
// PORTS
//  clk            in   1     clock, all state on posedge
//  rst            in   1     asynchronous, active-low reset
//  in_valid       in   1     record present on in_data
//  in_data        in   DATA_OUT_WIDTH  record
//  in_ready       out  1     record accepted when in_valid && in_ready
//  flush          in   1     one-cycle request: emit current partial word
//  q_write_en     out  1     word valid toward queue write_en
//  q_data         out  Q_DATA_WIDTH    word toward queue data_in
//  q_waitrequest  in   1     queue waitrequest; word held while high
//  busy           out  1     acc or output register non-empty, or flush pending
// BEHAVIOUR
//  - Reset (rst low, async): cnt=0, acc=0, out_valid=0, q_data=0, flush_pend=0,
//    timer=0. Outputs: q_write_en=0, q_data=0, busy=0, in_ready=1.
//  - Accumulator: record k (0-based) written to acc[k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH].
//    Unused slots and pad bits are 0. Bits [Q_DATA_WIDTH-1 -: CNT_WIDTH] = record count.
//  - accept = q_write_en && !q_waitrequest. q_data/q_write_en are registered.
//    They are held bit-stable while q_waitrequest=1.
//  - move = (cnt==REC_PER_WORD || (flush_pend && cnt!=0)) && (!out_valid || accept).
//    On move: out_data <= {cnt, acc}; out_valid <= 1; acc cleared.
//    Word appears on q_write_en the cycle after move.
//  - in_ready = (cnt < REC_PER_WORD) || move (combinational).
//    Record accepted in a move cycle goes to slot 0, cnt <= 1.
//    Sustained in_valid with waitrequest=0 gives 1 record/cycle, no bubbles.
//  - accept without move: out_valid <= 0.
//  - Flush: flush=1 sets flush_pend. A record accepted in the same cycle joins the
//    flushed word. flush_pend clears on move, or immediately if cnt==0 and no record
//    is accepted. Flush with cnt==0 emits nothing. flush while flush_pend is
//    idempotent.
//  - Latency: 3rd record accepted at cycle T -> q_write_en=1 at T+2 (move at T+1).
//  - Backpressure: full acc + out_valid held -> in_ready=0 until accept.
//    No record is dropped or duplicated. Reset mid-operation discards acc and
//    out_data; q_write_en drops asynchronously.
//  - busy = (cnt!=0) || out_valid || flush_pend.
// CONFIGURATION
//  PACKER_TIMEOUT_FLUSH_EN defined: timer counts cycles with cnt!=0 and no record
//   accepted; reset to 0 on any accept or move. At TIMEOUT_CYCLES, an internal flush
//   request acts as a flush pulse, so trickle records never stall in the packer.
//  Undefined: no timer logic; partial words leave only via explicit flush.
// TESTING
//  1 Reset: rst low mid-stream -> q_write_en=0, in_ready=1, busy=0 immediately.
//    After release, first word is built from post-reset records only.
//  2 Stream 6 records 0x1..0x6 back-to-back, waitrequest=0 -> 2 words:
//    word0 = {2'd3, pad 0, 0x3, 0x2, 0x1}, word1 = {2'd3, ..., 0x6, 0x5, 0x4}.
//    in_ready stays 1 throughout.
//  3 2 records 0xA,0xB then flush -> 1 word, count=2, slot2=0. Flush with cnt=0
//    -> no write, busy returns 0.
//  4 waitrequest=1 for 10 cycles while streaming -> q_data stable.
//    in_ready=0 after 3 more records; after release, words drain in order,
//    with no loss or duplication (scoreboard).
//  5 flush and in_valid in same cycle with cnt=1 -> single word, count=2.
//  6 (PACKER_TIMEOUT_FLUSH_EN, TIMEOUT_CYCLES=64) 1 record then idle ->
//    word count=1 emitted at 64+2 cycles after accept. Without macro: none.

Source files
------------

// File: rtl/record_packer.sv
// record_packer: packs fixed-width records LSB-first into queue-width words.
// The record count sits in the top CNT_WIDTH bits of every word.
// Partial words leave on an explicit flush request.
// Optional build macro PACKER_TIMEOUT_FLUSH_EN adds an idle timer. When it
// expires, the timer raises an internal flush so trickle records are not
// held in the packer indefinitely.
module record_packer #(
   parameter int Q_DATA_WIDTH   = 128,
   parameter int DATA_OUT_WIDTH = 42,
   parameter int CNT_WIDTH      = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [DATA_OUT_WIDTH-1:0] in_data,
   output logic                      in_ready,
   input  logic                      flush,
   output logic                      q_write_en,
   output logic [Q_DATA_WIDTH-1:0]   q_data,
   input  logic                      q_waitrequest,
   output logic                      busy
);

   localparam int REC_PER_WORD = Q_DATA_WIDTH / DATA_OUT_WIDTH;
   localparam int ACC_W        = REC_PER_WORD * DATA_OUT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(REC_PER_WORD);

   if ((ACC_W + CNT_WIDTH > Q_DATA_WIDTH) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("record_packer: record slots plus count field exceed word width, or bad timeout");
   end

   logic [ACC_W-1:0]        acc_p0, acc_nxt;
   logic [CNT_WIDTH-1:0]    cnt_p0, cnt_nxt;
   logic                    flush_pend_p0, flush_pend_nxt;
   logic                    vld_p1;
   logic [Q_DATA_WIDTH-1:0] q_data_p1;
   logic                    accept, move, fire, flush_req;

   // Word layout: count on top, records from bit 0 upward, pad bits zero.
   function automatic logic [Q_DATA_WIDTH-1:0] pack_word(input logic [CNT_WIDTH-1:0] n,
                                                         input logic [ACC_W-1:0]     a);
      logic [Q_DATA_WIDTH-1:0] w;
      w = '0;
      w[ACC_W-1:0] = a;
      w[Q_DATA_WIDTH-1 -: CNT_WIDTH] = n;
      return w;
   endfunction

   assign accept     = vld_p1 && !q_waitrequest;
   assign move       = ((cnt_p0 == FULL_CNT) || (flush_pend_p0 && (cnt_p0 != '0)))
                       && (!vld_p1 || accept);
   assign in_ready   = (cnt_p0 < FULL_CNT) || move;
   assign fire       = in_valid && in_ready;
   assign q_write_en = vld_p1;
   assign q_data     = q_data_p1;
   assign busy       = (cnt_p0 != '0) || vld_p1 || flush_pend_p0;

`ifdef PACKER_TIMEOUT_FLUSH_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_HIT = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
   logic [TMR_W-1:0] timer_p0;

   // The idle cycle on which the timer reads TIMEOUT_CYCLES-1 is the last one allowed.
   assign flush_req = flush || ((cnt_p0 != '0) && !fire && (timer_p0 == TMR_HIT));

   // Count idle cycles while records wait; saturate so the flush is not re-armed by wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_p0 <= '0;
      end else if (fire || move || (cnt_p0 == '0)) begin
         timer_p0 <= '0;
      end else if (timer_p0 != TMR_MAX) begin
         timer_p0 <= timer_p0 + TMR_W'(1);
      end
   end
`else
   assign flush_req = flush;
`endif

   // Next accumulator state: a move empties it, and a record accepted in that cycle lands in slot 0.
   always_comb begin
      acc_nxt = move ? '0 : acc_p0;
      cnt_nxt = move ? '0 : cnt_p0;
      if (fire) begin
         for (int k = 0; k < REC_PER_WORD; k++) begin
            if (cnt_nxt == CNT_WIDTH'(k)) begin
               acc_nxt[k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] = in_data;
            end
         end
         cnt_nxt = cnt_nxt + CNT_WIDTH'(1);
      end
      flush_pend_nxt = ((flush_pend_p0 && !move) || flush_req) && (cnt_nxt != '0);
   end

   // Stage p0: accumulator, record count and pending flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_p0        <= '0;
         cnt_p0        <= '0;
         flush_pend_p0 <= 1'b0;
      end else begin
         acc_p0        <= acc_nxt;
         cnt_p0        <= cnt_nxt;
         flush_pend_p0 <= flush_pend_nxt;
      end
   end

   // Stage p1: output word register, held unchanged until the queue accepts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1    <= 1'b0;
         q_data_p1 <= '0;
      end else if (move) begin
         vld_p1    <= 1'b1;
         q_data_p1 <= pack_word(cnt_p0, acc_p0);
      end else if (accept) begin
         vld_p1    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_record_packer.sv
// Testbench for record_packer (default parameters: 128-bit word, 42-bit records).
module tb_record_packer;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [41:0]  in_data = '0;
   logic         flush = 1'b0;
   logic         q_waitrequest = 1'b0;
   logic         in_ready, q_write_en, busy;
   logic [127:0] q_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   record_packer dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .flush         (flush),
      .q_write_en    (q_write_en),
      .q_data        (q_data),
      .q_waitrequest (q_waitrequest),
      .busy          (busy)
   );

   typedef struct packed {
      logic         v;
      logic [41:0]  d;
      logic         f;
      logic         we;
      logic [127:0] data;
      logic         rdy;
      logic         bsy;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];

   logic [127:0] expq[$];
   logic [41:0]  r [3];
   int           rc;

   function automatic logic [127:0] mkword(input int n, input logic [41:0] r0,
                                           input logic [41:0] r1, input logic [41:0] r2);
      logic [1:0] c;
      c = 2'(n);
      return {c, r2, r1, r0};
   endfunction

   function automatic vec_t mk(input logic v, input logic [41:0] d, input logic f,
                               input logic we, input logic [127:0] data,
                               input logic rdy, input logic bsy);
      vec_t t;
      t.v = v; t.d = d; t.f = f; t.we = we; t.data = data; t.rdy = rdy; t.bsy = bsy;
      return t;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_push(input logic [41:0] d);
      r[rc] = d;
      rc++;
      if (rc == 3) begin
         expq.push_back(mkword(3, r[0], r[1], r[2]));
         rc = 0;
      end
   endtask

   // Wait (bounded) for the next word, compare it, then return at posedge+1.
   task automatic wait_word(input string name, input logic [127:0] exp, input int limit);
      bit found;
      found = 0;
      for (int k = 0; k < limit && !found; k++) begin
         @(negedge clk);
         if (q_write_en) begin
            found = 1;
            chk(name, q_data, exp);
         end
      end
      if (!found) chk({name, "_timeout"}, 128'(found), 128'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [127:0] held;
      bit           held_set;
      int           nxt, got, lat, nwords;
      bit           found;

      tbl[0]  = mk(1, 42'h1, 0, 0, '0, 1, 0);
      tbl[1]  = mk(1, 42'h2, 0, 0, '0, 1, 1);
      tbl[2]  = mk(1, 42'h3, 0, 0, '0, 1, 1);
      tbl[3]  = mk(1, 42'h4, 0, 0, '0, 1, 1);
      tbl[4]  = mk(1, 42'h5, 0, 1, mkword(3, 42'h1, 42'h2, 42'h3), 1, 1);
      tbl[5]  = mk(1, 42'h6, 0, 0, '0, 1, 1);
      tbl[6]  = mk(0, 42'h0, 0, 0, '0, 1, 1);
      tbl[7]  = mk(0, 42'h0, 0, 1, mkword(3, 42'h4, 42'h5, 42'h6), 1, 1);
      tbl[8]  = mk(0, 42'h0, 0, 0, '0, 1, 0);
      tbl[9]  = mk(1, 42'hA, 0, 0, '0, 1, 0);
      tbl[10] = mk(1, 42'hB, 0, 0, '0, 1, 1);
      tbl[11] = mk(0, 42'h0, 1, 0, '0, 1, 1);
      tbl[12] = mk(0, 42'h0, 0, 0, '0, 1, 1);
      tbl[13] = mk(0, 42'h0, 0, 1, mkword(2, 42'hA, 42'hB, 42'h0), 1, 1);
      tbl[14] = mk(0, 42'h0, 1, 0, '0, 1, 0);
      tbl[15] = mk(0, 42'h0, 0, 0, '0, 1, 0);
      tbl[16] = mk(0, 42'h0, 0, 0, '0, 1, 0);
      tbl[17] = mk(1, 42'h7, 0, 0, '0, 1, 0);
      tbl[18] = mk(1, 42'h8, 1, 0, '0, 1, 1);
      tbl[19] = mk(0, 42'h0, 0, 0, '0, 1, 1);
      tbl[20] = mk(0, 42'h0, 0, 1, mkword(2, 42'h7, 42'h8, 42'h0), 1, 1);
      tbl[21] = mk(0, 42'h0, 0, 0, '0, 1, 0);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we", 128'(q_write_en), 128'(0));
      chk("rst_data", q_data, '0);
      chk("rst_ready", 128'(in_ready), 128'(1));
      chk("rst_busy", 128'(busy), 128'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset mid-stream with a word held by waitrequest
      q_waitrequest = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 42'h11 + 42'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("prerst_we", 128'(q_write_en), 128'(1));
      #2 rst = 1'b0;
      #1;
      chk("midrst_we", 128'(q_write_en), 128'(0));
      chk("midrst_ready", 128'(in_ready), 128'(1));
      chk("midrst_busy", 128'(busy), 128'(0));
      chk("midrst_data", q_data, '0);
      @(negedge clk);
      rst = 1'b1;
      q_waitrequest = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 42'h31 + 42'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_word("postrst_word", mkword(3, 42'h31, 42'h32, 42'h33), 10);

      // Directed vector table: streaming, flush, flush+record in one cycle
      for (int i = 0; i < NV; i++) begin
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         flush    = tbl[i].f;
         @(negedge clk);
         chk($sformatf("v%0d_we", i), 128'(q_write_en), 128'(tbl[i].we));
         if (tbl[i].we) chk($sformatf("v%0d_data", i), q_data, tbl[i].data);
         chk($sformatf("v%0d_ready", i), 128'(in_ready), 128'(tbl[i].rdy));
         chk($sformatf("v%0d_busy", i), 128'(busy), 128'(tbl[i].bsy));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      flush = 1'b0;

      // Backpressure: 10 cycles of waitrequest while streaming, then drain
      rc = 0;
      nxt = 1;
      got = 0;
      held_set = 0;
      held = '0;
      q_waitrequest = 1'b1;
      in_valid = 1'b1;
      in_data = 42'(nxt);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) begin
            model_push(42'(nxt));
            nxt++;
         end
         if (q_write_en) begin
            if (!held_set) begin
               held = q_data;
               held_set = 1;
            end else begin
               chk("bp_hold_stable", q_data, held);
            end
         end
         @(posedge clk); #1;
         in_data = 42'(nxt);
      end
      @(negedge clk);
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      chk("bp_records_taken", 128'(nxt - 1), 128'(6));
      chk("bp_word_presented", 128'(held_set), 128'(1));
      @(posedge clk); #1;
      q_waitrequest = 1'b0;
      for (int k = 0; k < 60; k++) begin
         in_valid = (nxt <= 9);
         in_data  = 42'(nxt);
         @(negedge clk);
         if (in_valid && in_ready) begin
            model_push(42'(nxt));
            nxt++;
         end
         if (q_write_en) begin
            if (expq.size() == 0) chk("bp_extra_word", 128'(q_write_en), 128'(0));
            else begin
               chk($sformatf("bp_word%0d", got), q_data, expq.pop_front());
               got++;
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_word_count", 128'(got), 128'(3));
      chk("bp_record_count", 128'(nxt - 1), 128'(9));
      @(negedge clk);
      chk("bp_idle_busy", 128'(busy), 128'(0));
      @(posedge clk); #1;

      // Single trickle record, then idle
      in_valid = 1'b1;
      in_data = 42'h55;
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef PACKER_TIMEOUT_FLUSH_EN
      found = 0;
      lat = 0;
      for (int k = 1; k <= 100 && !found; k++) begin
         @(negedge clk);
         if (q_write_en) begin
            found = 1;
            lat = k;
            chk("to_word", q_data, mkword(1, 42'h55, 42'h0, 42'h0));
         end
      end
      chk("to_latency", 128'(lat), 128'(66));
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_busy_after", 128'(busy), 128'(0));
`else
      nwords = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (q_write_en) nwords++;
      end
      chk("noto_words", 128'(nwords), 128'(0));
      chk("noto_busy", 128'(busy), 128'(1));
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_word("noto_flush_word", mkword(1, 42'h55, 42'h0, 42'h0), 10);
      @(negedge clk);
      chk("noto_busy_after", 128'(busy), 128'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
